core_ctrl: RTL and testbench
============================

// Module: core_ctrl
// PURPOSE
//   Inter-core control unit. It sits downstream of every core's write-back
//   stage and consumes each core's awaken (pc_out) and pause/resume
//   (pauseResume) requests. It feeds each core's pc_passed and stall_num
//   inputs, owns a per-core run-state FSM, boots core 0 out of reset, and
//   arbitrates conflicting requests.
// PARAMETERS
//   NCORES    4       number of cores; the target field is 2 bits, so the maximum is 4
//   BOOT_PC   16'h0   PC handed to core 0 after reset
//   STALL_WB  3'd6    stall_num value that freezes a whole core pipeline
// PORTS
//   clk            in   1          system clock
//   rst_n          in   1          asynchronous, active-low reset
//   pause_resume_i in   4*NCORES   per core {valid, resume, target[1:0]}; core i at [4i+:4]
//   pc_out_i       in   19*NCORES  per core {valid, target[1:0], pc[15:0]}; core i at [19i+:19]
//   halt_i         in   NCORES     per core sticky halt flag
//   pc_passed_o    out  17*NCORES  per core {wake_valid, pc[15:0]}
//   stall_num_o    out  3*NCORES   per core stall request
//   core_state_o   out  3*NCORES   per core FSM state, for debug
//   all_halted_o   out  1          every core is SLEEP or HALTED, and no WAKE is pending
// BEHAVIOUR
//   Clock and reset
//   - One clock. Reset is asynchronous and active-low.
//   Reset
//   - Core 0 state = WAKE with latched pc = BOOT_PC. All other cores = SLEEP.
//   - pc_passed_o = 0, all_halted_o = 0.
//   - The first clk edge after rst_n deasserts is the earliest edge at which core 0 is woken.
//   Per-core FSM (3-bit encoding)
//   - States: SLEEP=0, WAKE=1, RUN=2, PAUSED=3, HALTED=4.
//   - SLEEP  -> WAKE    on a granted awaken to this core; latch the pc.
//   - WAKE   -> RUN     unconditionally after 1 cycle.
//   - RUN    -> PAUSED  on a granted pause.
//   - PAUSED -> RUN     on a granted resume.
//   - RUN/PAUSED -> HALTED  when halt_i[i] is high. HALTED is sticky until reset.
//   - halt_i takes priority over any request targeting the same core in the same cycle.
//   Outputs
//   - pc_passed_o[i] = {1, latched pc} only while state == WAKE (exactly 1 cycle); otherwise 0.
//   - stall_num_o[i] = STALL_WB if state == PAUSED, or if core i loses arbitration this
//     cycle (combinational); otherwise 0.
//   Requests
//   - A request is live iff its valid bit = 1 and the requester's state == RUN.
//     Requests from SLEEP, WAKE, PAUSED or HALTED cores are ignored. This absorbs the
//     repeat assertion from a self-paused core whose write-back stage is frozen.
//   - Awaken takes effect only if the target is SLEEP.
//   - Pause takes effect only if the target is RUN. Resume takes effect only if the
//     target is PAUSED.
//   - A request whose target is in the wrong state is consumed (granted) with no
//     effect; it never stalls the requester.
//   - Self-pause is legal. Only another core can then resume it.
//   Arbitration (per target, per cycle)
//   - Among live requests to the same target, the lowest requester index wins.
//   - A core with both awaken and pause/resume valid: the awaken is arbitrated first;
//     its pause/resume is treated as a loser and retried.
//   - Losers get stall_num_o = STALL_WB in the same cycle, which holds their write-back
//     instruction; they retry the next cycle.
//   Latency and ordering
//   - A grant at edge N gives the new state after edge N. The target sees
//     pc_passed/stall_num during cycle N+1.
//   - Reset asserted mid-operation: all state returns to reset values immediately,
//     and latched PCs and pending losers are discarded.
//   - all_halted_o is registered and updates 1 cycle after the last core halts.
// STRUCTURE
//   - core_ctrl_defs.vh: state localparams, STALL_WB, and field offsets of the
//     pause_resume and pc_out buses.
//   - Sub-module core_ctrl_fsm: one instance per core. It holds state and the latched
//     pc, takes grant/kind/pc/halt, and drives pc_passed and the paused flag.
//   - Arbitration and stall generation are combinational in core_ctrl.
// TESTING
//   - Reset release -> core 0 gets pc_passed = {1, 16'h0000} for exactly 1 cycle, then
//     RUN. Cores 1-3 stay SLEEP with pc_passed = 0.
//   - Core 0 awakens core 2 with pc 16'h0100 -> next cycle pc_passed_o[2] = 17'h10100
//     for 1 cycle, then state RUN.
//   - Core 0 pauses core 1 (RUN) -> stall_num_o[1] = 6 from the next cycle. Core 0
//     resumes core 1 -> stall_num_o[1] = 0 the cycle after.
//   - Cores 1 and 3 both awaken core 2 in the same cycle -> core 1 wins, and
//     stall_num_o[3] = 6 that cycle. On the retry, core 2 is WAKE/RUN, so the request
//     is consumed with no effect and stall_num_o[3] = 0.
//   - Core 1 self-pauses with a held request -> PAUSED, no re-trigger. Core 0 resumes
//     core 1 -> RUN. halt_i[1] in the same cycle as the resume -> HALTED.
//   - All cores halt -> all_halted_o = 1 one cycle later. Assert rst_n low mid-run ->
//     every output returns to its reset value immediately.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types and bus field offsets for the inter-core control unit.
// Imported by core_ctrl and core_ctrl_fsm.
package core_ctrl_pkg;

    localparam int PC_W = 16;
    localparam int PR_W = 4;
    localparam int PO_W = 19;
    localparam int PP_W = 17;
    localparam int ST_W = 3;

    localparam int PR_VALID  = 3;
    localparam int PR_RESUME = 2;
    localparam int PR_TGT    = 0;

    localparam int PO_VALID = 18;
    localparam int PO_TGT   = 16;
    localparam int PO_PC    = 0;

    localparam logic [2:0] STALL_WB_DEF = 3'd6;

    typedef enum logic [2:0] {
        ST_SLEEP  = 3'd0,
        ST_WAKE   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_HALTED = 3'd4
    } core_state_e;

    typedef enum logic [1:0] {
        K_AWAKEN = 2'd0,
        K_PAUSE  = 2'd1,
        K_RESUME = 2'd2
    } req_kind_e;

    typedef struct packed {
        logic            live;
        logic [1:0]      tgt;
        req_kind_e       kind;
        logic [PC_W-1:0] pc;
    } req_t;

endpackage

// File: rtl/core_ctrl_fsm.sv
// Per-core run-state machine: holds the run state and the latched
// wake-up PC, and presents the one-cycle pc_passed pulse.
module core_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter logic            RST_WAKE = 1'b0,
    parameter logic [PC_W-1:0] BOOT_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold_i,
    input  logic            grant_i,
    input  req_kind_e       kind_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            halt_i,
    output core_state_e     state_o,
    output logic [PP_W-1:0] pc_passed_o,
    output logic            paused_o
);

    core_state_e     state_q;
    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_WAKE ? ST_WAKE : ST_SLEEP;
            pc_q    <= RST_WAKE ? BOOT_PC : '0;
        end else begin
            case (state_q)
                ST_SLEEP: begin
                    if (grant_i && kind_i == K_AWAKEN) begin
                        state_q <= ST_WAKE;
                        pc_q    <= pc_i;
                    end
                end
                ST_WAKE: begin
                    if (!hold_i) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt_i)
                        state_q <= ST_HALTED;
                    else if (grant_i && kind_i == K_PAUSE)
                        state_q <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (halt_i)
                        state_q <= ST_HALTED;
                    else if (grant_i && kind_i == K_RESUME)
                        state_q <= ST_RUN;
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_SLEEP;
            endcase
        end
    end

    // hold_i masks the boot wake until the first edge after reset
    assign pc_passed_o = (state_q == ST_WAKE && !hold_i)
                       ? {1'b1, pc_q} : '0;
    assign paused_o    = (state_q == ST_PAUSED);
    assign state_o     = state_q;

endmodule

// File: rtl/core_ctrl.sv
// Inter-core control: request qualification, per-target arbitration,
// stall generation and the per-core run-state machines.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int              NCORES   = 4,
    parameter logic [PC_W-1:0] BOOT_PC  = 16'h0,
    parameter logic [2:0]      STALL_WB = STALL_WB_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PR_W*NCORES-1:0] pause_resume_i,
    input  logic [PO_W*NCORES-1:0] pc_out_i,
    input  logic [NCORES-1:0]      halt_i,
    output logic [PP_W*NCORES-1:0] pc_passed_o,
    output logic [3*NCORES-1:0]    stall_num_o,
    output logic [ST_W*NCORES-1:0] core_state_o,
    output logic                   all_halted_o
);

    core_state_e     st     [NCORES];
    req_t            req    [NCORES];
    req_kind_e       g_kind [NCORES];
    logic [PC_W-1:0] g_pc   [NCORES];

    logic [NCORES-1:0] paused;
    logic [NCORES-1:0] defer;
    logic [NCORES-1:0] lose;
    logic [NCORES-1:0] grant;

    logic boot_q;
    logic all_halted_q, all_halted_d;

    always_comb begin
        for (int r = 0; r < NCORES; r++) begin
            logic run, aw_v, pr_v, pr_res;
            run    = (st[r] == ST_RUN);
            aw_v   = pc_out_i[r*PO_W + PO_VALID] && run;
            pr_v   = pause_resume_i[r*PR_W + PR_VALID] && run;
            pr_res = pause_resume_i[r*PR_W + PR_RESUME];
            req[r].live = aw_v || pr_v;
            req[r].tgt  = aw_v ? pc_out_i[r*PO_W + PO_TGT +: 2]
                               : pause_resume_i[r*PR_W + PR_TGT +: 2];
            req[r].kind = aw_v ? K_AWAKEN
                        : (pr_res ? K_RESUME : K_PAUSE);
            req[r].pc   = pc_out_i[r*PO_W + PO_PC +: PC_W];
            // awaken goes first; the pause/resume waits a cycle
            defer[r]    = aw_v && pr_v;
        end
    end

    always_comb begin
        lose  = '0;
        grant = '0;
        for (int t = 0; t < NCORES; t++) begin
            g_kind[t] = K_AWAKEN;
            g_pc[t]   = '0;
        end
        for (int r = 1; r < NCORES; r++) begin
            for (int j = 0; j < r; j++) begin
                if (req[j].live && req[r].live &&
                    req[j].tgt == req[r].tgt)
                    lose[r] = 1'b1;
            end
        end
        // scan high to low so the lowest requester lands last
        for (int t = 0; t < NCORES; t++) begin
            for (int r = NCORES - 1; r >= 0; r--) begin
                if (req[r].live && req[r].tgt == 2'(t)) begin
                    grant[t]  = 1'b1;
                    g_kind[t] = req[r].kind;
                    g_pc[t]   = req[r].pc;
                end
            end
        end
    end

    always_comb begin
        all_halted_d = 1'b1;
        for (int i = 0; i < NCORES; i++) begin
            if (!(st[i] == ST_SLEEP || st[i] == ST_HALTED))
                all_halted_d = 1'b0;
            if (grant[i] && g_kind[i] == K_AWAKEN &&
                st[i] == ST_SLEEP)
                all_halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_q       <= 1'b1;
            all_halted_q <= 1'b0;
        end else begin
            boot_q       <= 1'b0;
            all_halted_q <= all_halted_d;
        end
    end

    assign all_halted_o = all_halted_q;

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        core_ctrl_fsm #(
            .RST_WAKE ((i == 0)),
            .BOOT_PC  (BOOT_PC)
        ) u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .hold_i      ((i == 0) && boot_q),
            .grant_i     (grant[i]),
            .kind_i      (g_kind[i]),
            .pc_i        (g_pc[i]),
            .halt_i      (halt_i[i]),
            .state_o     (st[i]),
            .pc_passed_o (pc_passed_o[i*PP_W +: PP_W]),
            .paused_o    (paused[i])
        );

        assign core_state_o[i*ST_W +: ST_W] = st[i];
        assign stall_num_o[i*3 +: 3] =
            (paused[i] || lose[i] || defer[i]) ? STALL_WB : 3'd0;
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized and directed stimulus for core_ctrl, checked every cycle
// against a behavioural model of the run-state rules.
module tb_core_ctrl;

    localparam int S_SLEEP  = 0;
    localparam int S_WAKE   = 1;
    localparam int S_RUN    = 2;
    localparam int S_PAUSED = 3;
    localparam int S_HALTED = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] pause_resume_i;
    logic [75:0] pc_out_i;
    logic [3:0]  halt_i;
    logic [67:0] pc_passed_o;
    logic [11:0] stall_num_o;
    logic [11:0] core_state_o;
    logic        all_halted_o;

    core_ctrl #(
        .NCORES   (4),
        .BOOT_PC  (16'h0),
        .STALL_WB (3'd6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pause_resume_i (pause_resume_i),
        .pc_out_i       (pc_out_i),
        .halt_i         (halt_i),
        .pc_passed_o    (pc_passed_o),
        .stall_num_o    (stall_num_o),
        .core_state_o   (core_state_o),
        .all_halted_o   (all_halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          mst [4];
    logic [15:0] mpc [4];
    bit          mboot;
    bit          mallh;

    task automatic check(input string tag,
                         input logic [67:0] got,
                         input logic [67:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            mst[i] = S_SLEEP;
            mpc[i] = 16'h0;
        end
        mst[0] = S_WAKE;
        mboot  = 1'b1;
        mallh  = 1'b0;
    endfunction

    function automatic logic [75:0] mk_aw(int r, int t,
                                          logic [15:0] pc);
        logic [75:0] v;
        v = '0;
        v[r*19 +: 19] = {1'b1, 2'(t), pc};
        return v;
    endfunction

    function automatic logic [15:0] mk_pr(int r, int t, bit res);
        logic [15:0] v;
        v = '0;
        v[r*4 +: 4] = {1'b1, res, 2'(t)};
        return v;
    endfunction

    // called just after a posedge; compares at the following negedge
    task automatic cycle(input logic [15:0] pr,
                         input logic [75:0] po,
                         input logic [3:0]  h);
        int          win [4];
        int          knd [4];
        logic [15:0] wpc [4];
        bit          stl [4];
        int          nst [4];
        bit          aw, ps, any_wake, quiet, held;
        int          t, k;
        logic [16:0] exp_pp;
        pause_resume_i = pr;
        pc_out_i       = po;
        halt_i         = h;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            win[i] = -1;
            knd[i] = 0;
            wpc[i] = '0;
        end
        for (int r = 0; r < 4; r++) begin
            aw = po[r*19+18] && (mst[r] == S_RUN);
            ps = pr[r*4+3]   && (mst[r] == S_RUN);
            stl[r] = (mst[r] == S_PAUSED) || (aw && ps);
            if (aw || ps) begin
                t = aw ? int'(po[r*19+16 +: 2]) : int'(pr[r*4 +: 2]);
                k = aw ? 0 : (pr[r*4+2] ? 2 : 1);
                if (win[t] < 0) begin
                    win[t] = r;
                    knd[t] = k;
                    wpc[t] = po[r*19 +: 16];
                end else begin
                    stl[r] = 1'b1;
                end
            end
        end
        for (int r = 0; r < 4; r++) begin
            held   = (r == 0) && mboot;
            exp_pp = (mst[r] == S_WAKE && !held)
                   ? {1'b1, mpc[r]} : 17'h0;
            check($sformatf("pc_passed%0d", r),
                  68'(pc_passed_o[r*17 +: 17]), 68'(exp_pp));
            check($sformatf("stall%0d", r),
                  68'(stall_num_o[r*3 +: 3]), stl[r] ? 68'd6 : 68'd0);
            check($sformatf("state%0d", r),
                  68'(core_state_o[r*3 +: 3]), 68'(mst[r]));
        end
        check("all_halted", 68'(all_halted_o), 68'(mallh));
        any_wake = 1'b0;
        quiet    = 1'b1;
        for (int r = 0; r < 4; r++) begin
            nst[r] = mst[r];
            if (mst[r] == S_WAKE && !((r == 0) && mboot))
                nst[r] = S_RUN;
        end
        for (int i = 0; i < 4; i++) begin
            if (win[i] >= 0) begin
                if (knd[i] == 0 && mst[i] == S_SLEEP) begin
                    nst[i]   = S_WAKE;
                    mpc[i]   = wpc[i];
                    any_wake = 1'b1;
                end
                if (knd[i] == 1 && mst[i] == S_RUN)
                    nst[i] = S_PAUSED;
                if (knd[i] == 2 && mst[i] == S_PAUSED)
                    nst[i] = S_RUN;
            end
        end
        for (int r = 0; r < 4; r++) begin
            if (h[r] && (mst[r] == S_RUN || mst[r] == S_PAUSED))
                nst[r] = S_HALTED;
            if (!(mst[r] == S_SLEEP || mst[r] == S_HALTED))
                quiet = 1'b0;
        end
        mallh = quiet && !any_wake;
        mst   = nst;
        mboot = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // may be entered mid-run; reset values must appear at once
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc_passed", 68'(pc_passed_o), 68'h0);
        check("rst_state", 68'(core_state_o), 68'h001);
        check("rst_stall", 68'(stall_num_o), 68'h0);
        check("rst_all_halted", 68'(all_halted_o), 68'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] pr;
        logic [75:0] po;
        logic [3:0]  hf;
        rst_n          = 1'b0;
        pause_resume_i = '0;
        pc_out_i       = '0;
        halt_i         = '0;
        @(posedge clk);
        #1;

        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, mk_aw(0, 1, 16'h0040), 0);
        cycle(0, 0, 0);
        cycle(0, mk_aw(0, 2, 16'h0100), 0);
        cycle(0, 0, 0);
        cycle(0, mk_aw(0, 3, 16'h0200), 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(mk_pr(0, 1, 0), 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(mk_pr(0, 1, 1), 0, 0);
        cycle(0, 0, 0);
        repeat (3) cycle(mk_pr(1, 1, 0), 0, 0);
        cycle(mk_pr(0, 1, 1), 0, 4'b0010);
        cycle(0, 0, 4'b0010);
        cycle(mk_pr(0, 0, 0), mk_aw(0, 1, 16'h0001), 4'b0010);
        repeat (4) cycle(0, 0, 4'hF);

        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, mk_aw(0, 1, 16'h0010), 0);
        cycle(0, mk_aw(0, 3, 16'h0030), 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, mk_aw(1, 2, 16'h0100) | mk_aw(3, 2, 16'h0300), 0);
        cycle(0, mk_aw(3, 2, 16'h0300), 0);
        cycle(0, 0, 0);
        cycle(mk_pr(1, 3, 0) | mk_pr(2, 3, 0), 0, 0);
        cycle(mk_pr(2, 3, 0), 0, 0);
        cycle(mk_pr(1, 3, 1), 0, 0);
        repeat (3) cycle(0, 0, 0);

        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            hf = '0;
            for (int c = 0; c < 300; c++) begin
                pr = '0;
                po = '0;
                for (int r = 0; r < 4; r++) begin
                    if ($urandom_range(3) == 0)
                        pr[r*4 +: 4] = {1'b1, 1'($urandom_range(1)),
                                        2'($urandom_range(3))};
                    if ($urandom_range(2) == 0)
                        po[r*19 +: 19] = {1'b1, 2'($urandom_range(3)),
                                          16'($urandom)};
                    if ($urandom_range(149) == 0)
                        hf[r] = 1'b1;
                end
                cycle(pr, po, hf);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
